eth_tx_arbiter: RTL and testbench
=================================

Name: eth_tx_arbiter

Overview:
- Round-robin arbiter that shares the single ethernet write channel (o_wdata/o_wvalid/i_wready) between N byte-stream frame sources, e.g. the ping responder and frame_assembly instances.
- Grant is held for a whole frame, ending on the last byte.
- An inter-frame gap is enforced between frames.
- A frame is aborted if its source stalls or it exceeds the maximum length.
- Sits between the protocol-level frame producers and the eth TX interface.

Parameters:
- N, 2, number of requesters (2..8); requester 0 has first priority after reset.
- IFG, 12, idle cycles after each frame or abort before re-arbitration (>=1).
- TIMEOUT, 255, consecutive granted cycles with source valid low that trigger an abort (>=1).
- MAX_LEN, 1518, maximum bytes per frame; reaching it without last triggers an abort.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_req_valid  in  N  per-requester byte valid
- i_req_data  in  8*N  per-requester byte; requester k uses bits [8k+7:8k]
- i_req_last  in  N  marks final byte of frame, qualified by valid
- o_req_ready  out  N  byte accepted from requester k when valid[k]&ready[k]
- o_wdata  out  8  byte to eth TX
- o_wvalid  out  1  byte valid to eth TX
- i_wready  in  1  eth TX accepts byte when o_wvalid&i_wready
- o_grant  out  N  one-hot current owner, 0 when none
- o_busy  out  1  high in XFER or GAP
- o_abort  out  1  one-cycle pulse when a frame is aborted
- o_frames  out  16  count of frames completed with last, wraps 0xFFFF->0

Behaviour:
- Reset (i_rst=1 at a clock edge, any state including mid-frame):
  - state=IDLE; o_grant=0; o_busy=0; o_abort=0; o_frames=0.
  - RR pointer=N-1, so requester 0 is searched first.
  - Byte, timeout and gap counters cleared.
  - o_wvalid=0 and o_req_ready=0 while in IDLE.
- States: IDLE, XFER, GAP.
- IDLE:
  - If any i_req_valid is set, select the first set bit searching from pointer+1, wrapping modulo N.
  - Next cycle: o_grant=one-hot(sel), pointer=sel, state=XFER, byte and timeout counters cleared.
  - No bytes move in the arbitration cycle, so grant latency is 1 cycle.
- XFER datapath is combinational from the granted source (g):
  - o_wdata=data[g]; o_wvalid=valid[g].
  - o_req_ready[g]=i_wready; all other o_req_ready bits are 0.
  - Non-granted requesters are never accepted.
  - A beat is one cycle with valid[g]&i_wready.
- XFER counters:
  - Byte counter +1 per beat.
  - Timeout counter +1 on each cycle with valid[g]=0 and cleared on any cycle with valid[g]=1.
  - Backpressure (i_wready=0 with valid[g]=1) is not a stall and never times out.
- XFER exits, priority top-down:
  - Beat with last[g]=1: o_frames+1, o_grant=0, state=GAP.
  - Beat where byte count becomes MAX_LEN without last: o_abort pulse, o_grant=0, state=GAP.
  - Timeout counter reaches TIMEOUT: o_abort pulse, o_grant=0, state=GAP.
- After an abort:
  - The aborted source keeps its remaining bytes; the arbiter does not drain them.
  - The source must discard its frame on o_abort.
  - Rotation continues from the aborted requester.
- GAP:
  - o_wvalid=0; all o_req_ready=0; o_busy=1.
  - Counts IFG cycles, then state=IDLE.
  - Requests arriving during GAP wait; arbitration happens only in IDLE.
- o_busy: high in XFER and GAP, low in IDLE.
- Fairness: with all N requesters continuously valid, grants rotate 0,1,..,N-1,0. No requester waits more than N-1 frames.
- Single-byte frame: valid+last on the first beat is legal and completes immediately.
- Width rules:
  - Byte counter is 16 bits; MAX_LEN must be <= 65535.
  - Timeout counter width is clog2(TIMEOUT+1).
  - o_frames wraps silently.

Test Plan:
- Single frame, N=2: req0 sends 5 bytes (0xA0..0xA4), last on 0xA4, i_wready=1.
  - -> o_grant=01 one cycle after valid.
  - -> o_wdata shows A0..A4 on 5 consecutive cycles.
  - -> o_frames=1; o_busy low exactly IFG=12 cycles after the last beat.
- Round-robin: both requesters continuously send 3-byte frames.
  - -> grant order 0,1,0,1.
  - -> no bytes from the non-granted source appear on o_wdata.
  - -> o_frames=4 after four frames.
- Backpressure: i_wready toggles 1,0,0,1 during a frame from req1.
  - -> o_req_ready[1] tracks i_wready; no byte lost or duplicated.
  - -> no abort even with TIMEOUT=2.
- Timeout: TIMEOUT=4; req0 sends 2 bytes, then drops valid.
  - -> o_abort pulses once, 4 cycles after the last beat.
  - -> o_frames unchanged; GAP, then req1 is granted if valid.
- Max length: MAX_LEN=8; req1 streams 10 bytes, no last.
  - -> exactly 8 beats accepted; o_abort on the 8th beat cycle; o_req_ready[1]=0 afterwards.
- Reset mid-frame: assert i_rst after 3 bytes of a req0 frame.
  - -> next cycle o_grant=0, o_wvalid=0, o_busy=0, o_frames=0.
  - -> after release, with both valid, req0 is granted first.

Source files
------------

// File: rtl/eth_tx_arbiter.sv
// Round-robin owner of the single ethernet write channel: one source holds the
// channel for a whole frame, then an inter-frame gap runs before re-arbitration.
module eth_tx_arbiter #(
    parameter int N       = 2,
    parameter int IFG     = 12,
    parameter int TIMEOUT = 255,
    parameter int MAX_LEN = 1518
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N-1:0]     i_req_valid,
    input  logic [8*N-1:0]   i_req_data,
    input  logic [N-1:0]     i_req_last,
    output logic [N-1:0]     o_req_ready,
    output logic [7:0]       o_wdata,
    output logic             o_wvalid,
    input  logic             i_wready,
    output logic [N-1:0]     o_grant,
    output logic             o_busy,
    output logic             o_abort,
    output logic [15:0]      o_frames
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(IFG + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_n_s;
    logic [PW-1:0]   ptr_r;
    logic [N-1:0]    grant_r;
    logic [15:0]     byte_cnt_r;
    logic [TW-1:0]   to_cnt_r;
    logic [GW-1:0]   gap_cnt_r;
    logic [15:0]     frames_r;

    logic [PW-1:0]   sel_s;
    logic [PW-1:0]   idx_s;
    logic            found_s;
    logic [7:0]      gdata_s;
    logic            gvalid_s;
    logic            glast_s;
    logic            beat_s;
    logic            done_s;
    logic            len_abort_s;
    logic            to_abort_s;

    // Round-robin search: walk downwards so the candidate closest to ptr+1 wins
    always_comb begin
        sel_s   = ptr_r;
        idx_s   = ptr_r;
        found_s = |i_req_valid;
        for (int i = N; i >= 1; i--) begin
            idx_s = PW'((int'(ptr_r) + i) % N);
            sel_s = i_req_valid[idx_s] ? idx_s : sel_s;
        end
    end

    // Mux of the currently granted source (ptr_r holds the owner while in XFER)
    always_comb begin
        gdata_s  = 8'h00;
        gvalid_s = 1'b0;
        glast_s  = 1'b0;
        for (int k = 0; k < N; k++) begin
            gdata_s  = (ptr_r == PW'(k)) ? i_req_data[8*k +: 8] : gdata_s;
            gvalid_s = (ptr_r == PW'(k)) ? i_req_valid[k]       : gvalid_s;
            glast_s  = (ptr_r == PW'(k)) ? i_req_last[k]        : glast_s;
        end
    end

    // Channel datapath and frame exit conditions
    always_comb begin
        o_wdata     = 8'h00;
        o_wvalid    = 1'b0;
        o_req_ready = '0;
        beat_s      = 1'b0;
        case (state_r)
            XFER: begin
                o_wdata     = gdata_s;
                o_wvalid    = gvalid_s;
                o_req_ready = grant_r & {N{i_wready}};
                beat_s      = gvalid_s & i_wready;
            end
            default: begin
                beat_s = 1'b0;
            end
        endcase
        done_s      = beat_s & glast_s;
        len_abort_s = beat_s & ~glast_s & (byte_cnt_r == 16'(MAX_LEN - 1));
        to_abort_s  = (state_r == XFER) & ~gvalid_s & (to_cnt_r == TW'(TIMEOUT - 1));
        o_abort     = len_abort_s | to_abort_s;
    end

    // Next-state logic
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            IDLE: begin
                if (found_s) state_n_s = XFER;
                else         state_n_s = IDLE;
            end
            XFER: begin
                if (done_s || o_abort) state_n_s = GAP;
                else                   state_n_s = XFER;
            end
            GAP: begin
                if (gap_cnt_r == GW'(IFG - 1)) state_n_s = IDLE;
                else                           state_n_s = GAP;
            end
            default: state_n_s = IDLE;
        endcase
    end

    // State, grant and counter registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= IDLE;
            ptr_r      <= PW'(N - 1);
            grant_r    <= '0;
            byte_cnt_r <= 16'h0000;
            to_cnt_r   <= '0;
            gap_cnt_r  <= '0;
            frames_r   <= 16'h0000;
        end else begin
            state_r <= state_n_s;
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        grant_r    <= N'(1) << sel_s;
                        ptr_r      <= sel_s;
                        byte_cnt_r <= 16'h0000;
                        to_cnt_r   <= '0;
                    end
                end
                XFER: begin
                    byte_cnt_r <= byte_cnt_r + {15'h0000, beat_s};
                    to_cnt_r   <= gvalid_s ? '0 : to_cnt_r + TW'(1);
                    frames_r   <= frames_r + {15'h0000, done_s};
                    if (done_s || o_abort) begin
                        grant_r   <= '0;
                        gap_cnt_r <= '0;
                    end
                end
                GAP: begin
                    gap_cnt_r <= gap_cnt_r + GW'(1);
                end
                default: begin
                    grant_r <= '0;
                end
            endcase
        end
    end

    assign o_grant  = grant_r;
    assign o_busy   = (state_r != IDLE);
    assign o_frames = frames_r;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Bench for eth_tx_arbiter: queue-based sources drive directed frames; a
// scoreboard monitor checks every byte that leaves on the write channel.
module tb_eth_tx_arbiter;

    localparam int N       = 2;
    localparam int IFG     = 12;
    localparam int TIMEOUT = 4;
    localparam int MAX_LEN = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid;
    logic [15:0]  req_data;
    logic [1:0]   req_last;
    logic [1:0]   req_ready;
    logic [7:0]   wdata;
    logic         wvalid;
    logic         wready;
    logic [1:0]   grant;
    logic         busy;
    logic         abort;
    logic [15:0]  frames;

    eth_tx_arbiter #(.N(N), .IFG(IFG), .TIMEOUT(TIMEOUT), .MAX_LEN(MAX_LEN)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
        .i_req_last(req_last), .o_req_ready(req_ready), .o_wdata(wdata),
        .o_wvalid(wvalid), .i_wready(wready), .o_grant(grant), .o_busy(busy),
        .o_abort(abort), .o_frames(frames)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int misses  = 0;
    int cyc = 0;
    int last_beat_cyc = 0;
    int abort_cyc = 0;
    int abort_cnt = 0;
    int frame_beats = 0;
    logic [8:0] sq0[$];
    logic [8:0] sq1[$];
    logic [9:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            misses++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive();
        req_valid = 2'b00;
        req_data  = 16'h0000;
        req_last  = 2'b00;
        if (sq0.size() > 0) begin
            req_valid[0]   = 1'b1;
            req_data[7:0]  = sq0[0][7:0];
            req_last[0]    = sq0[0][8];
        end
        if (sq1.size() > 0) begin
            req_valid[1]   = 1'b1;
            req_data[15:8] = sq1[0][7:0];
            req_last[1]    = sq1[0][8];
        end
    endtask

    // Source k gets len bytes base, base+1, ...; the first n_exp are expected on the channel
    task automatic load(input int k, input logic [7:0] base, input int len,
                        input bit with_last, input int n_exp);
        logic [7:0] b;
        logic [1:0] g;
        g = (k == 0) ? 2'b01 : 2'b10;
        for (int i = 0; i < len; i++) begin
            b = base + 8'(i);
            if (k == 0) sq0.push_back({with_last && (i == len - 1), b});
            else        sq1.push_back({with_last && (i == len - 1), b});
            if (i < n_exp) exp_q.push_back({g, b});
        end
    endtask

    task automatic tick();
        logic [1:0] acc;
        logic       ab;
        logic [1:0] g;
        @(negedge clk);
        acc = req_valid & req_ready;
        ab  = abort;
        g   = grant;
        if (!rst) begin
            if (acc != 2'b00) begin
                last_beat_cyc = cyc;
                frame_beats++;
            end
            if (ab) begin
                abort_cnt++;
                abort_cyc = cyc;
            end
        end
        @(posedge clk);
        #1;
        if (acc[0] && sq0.size() > 0) void'(sq0.pop_front());
        if (acc[1] && sq1.size() > 0) void'(sq1.pop_front());
        if (ab && g[0]) sq0.delete();
        if (ab && g[1]) sq1.delete();
        cyc++;
        drive();
    endtask

    task automatic wait_idle(input string name, input int lim);
        int n = 0;
        while ((busy || sq0.size() > 0 || sq1.size() > 0) && n < lim) begin
            tick();
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_grant(input string name, input logic [1:0] req, input int lim);
        int n = 0;
        while (grant == 2'b00 && n < lim) begin
            tick();
            n++;
        end
        check(name, {30'd0, grant}, {30'd0, req});
    endtask

    // Scoreboard monitor: every accepted channel byte must match the next expected one
    always @(negedge clk) begin
        if (!rst) begin
            check("ready_vs_grant", {30'd0, req_ready}, {30'd0, grant & {2{wready}}});
            if (wvalid && wready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {22'd0, grant, wdata}, 32'hFFFF_FFFF);
                end else begin
                    check("channel_byte", {22'd0, grant, wdata}, {22'd0, exp_q[0]});
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [8:0] pat [9];
    int n;
    int ab0;

    initial begin
        pat = '{9'd1, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd1, 9'd1, 9'd1};
        rst = 1'b1;
        wready = 1'b1;
        drive();
        tick();
        tick();
        check("rst_grant",  {30'd0, grant}, 32'd0);
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_frames", {16'd0, frames}, 32'd0);
        check("rst_wvalid", {31'd0, wvalid}, 32'd0);
        check("rst_ready",  {30'd0, req_ready}, 32'd0);
        rst = 1'b0;

        // Single 5-byte frame from requester 0
        load(0, 8'hA0, 5, 1'b1, 5);
        drive();
        tick();
        check("t1_grant", {30'd0, grant}, 32'd1);
        frame_beats = 0;
        for (int i = 0; i < 5; i++) tick();
        check("t1_beats",  frame_beats, 32'd5);
        check("t1_frames", {16'd0, frames}, 32'd1);
        check("t1_gap_grant", {30'd0, grant}, 32'd0);
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check("t1_gap_len", n, 32'd12);

        // Round robin after reset: 0,1,0,1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t2_frames_cleared", {16'd0, frames}, 32'd0);
        load(0, 8'hB0, 3, 1'b1, 3);
        load(1, 8'hC0, 3, 1'b1, 3);
        load(0, 8'hB3, 3, 1'b1, 3);
        load(1, 8'hC3, 3, 1'b1, 3);
        drive();
        wait_idle("t2_idle", 300);
        check("t2_frames", {16'd0, frames}, 32'd4);
        check("t2_aborts", abort_cnt, 32'd0);

        // Backpressure on requester 1 with a stall longer than TIMEOUT
        load(1, 8'hD0, 4, 1'b1, 4);
        drive();
        tick();
        check("t3_grant", {30'd0, grant}, 32'd2);
        for (int i = 0; i < 9; i++) begin
            wready = pat[i][0];
            tick();
        end
        wready = 1'b1;
        check("t3_src_empty", sq1.size(), 32'd0);
        check("t3_frames", {16'd0, frames}, 32'd5);
        check("t3_aborts", abort_cnt, 32'd0);
        wait_idle("t3_idle", 40);

        // Timeout: requester 0 stalls after two bytes, requester 1 waits
        load(0, 8'hE0, 2, 1'b0, 2);
        drive();
        tick();
        check("t4_grant0", {30'd0, grant}, 32'd1);
        load(1, 8'hF0, 2, 1'b1, 2);
        drive();
        ab0 = abort_cnt;
        n = 0;
        while (abort_cnt == ab0 && n < 20) begin
            tick();
            n++;
        end
        check("t4_abort_once", abort_cnt - ab0, 32'd1);
        check("t4_abort_delay", abort_cyc - last_beat_cyc, 32'd4);
        check("t4_frames_kept", {16'd0, frames}, 32'd5);
        wait_grant("t4_grant1", 2'b10, 30);
        wait_idle("t4_idle", 40);
        check("t4_frames", {16'd0, frames}, 32'd6);
        check("t4_no_extra_abort", abort_cnt - ab0, 32'd1);

        // Maximum length: 10 bytes offered without last, only 8 accepted
        ab0 = abort_cnt;
        frame_beats = 0;
        load(1, 8'h50, 10, 1'b0, 8);
        drive();
        n = 0;
        while (abort_cnt == ab0 && n < 30) begin
            tick();
            n++;
        end
        check("t5_beats", frame_beats, 32'd8);
        check("t5_abort_on_beat", abort_cyc - last_beat_cyc, 32'd0);
        check("t5_ready_after", {30'd0, req_ready}, 32'd0);
        check("t5_grant_after", {30'd0, grant}, 32'd0);
        check("t5_frames", {16'd0, frames}, 32'd6);
        wait_idle("t5_idle", 40);

        // Reset in the middle of a frame, then single-byte frames from both
        frame_beats = 0;
        load(0, 8'h10, 6, 1'b1, 3);
        drive();
        n = 0;
        while (frame_beats < 3 && n < 20) begin
            tick();
            n++;
        end
        rst = 1'b1;
        tick();
        check("t6_grant",  {30'd0, grant}, 32'd0);
        check("t6_wvalid", {31'd0, wvalid}, 32'd0);
        check("t6_busy",   {31'd0, busy}, 32'd0);
        check("t6_frames", {16'd0, frames}, 32'd0);
        sq0.delete();
        rst = 1'b0;
        load(0, 8'h77, 1, 1'b1, 1);
        load(1, 8'h88, 1, 1'b1, 1);
        drive();
        wait_grant("t6_first_grant", 2'b01, 10);
        wait_idle("t6_idle", 60);
        check("t6_frames_after", {16'd0, frames}, 32'd2);
        check("exp_queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
